// File: rtl/cmp_pkg.sv
// Shared types for the sequential digit comparator.
//   cmp_state_e : FSM state encoding (CMP_IDLE, CMP_SCAN, CMP_DONE)
//   cmp_res_e   : internal comparison result before decode to output flags
//   cmp_flags() : result -> {lt, eq, gt} one-hot flag vector
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_SCAN = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_e;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

  // Returns {less, equal, greater}.
  function automatic logic [2:0] cmp_flags(input cmp_res_e res);
    logic [2:0] flags;
    flags = 3'b000;
    unique case (res)
      CMP_LT:  flags = 3'b100;
      CMP_EQ:  flags = 3'b010;
      CMP_GT:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
// Ports:
//   i_a, i_b : digits to compare
//   o_lt     : i_a <  i_b
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  always_comb begin
    o_lt = (i_a < i_b);
    o_eq = (i_a == i_b);
    o_gt = (i_a > i_b);
  end

endmodule

// File: rtl/seq_digit_comparator.sv
// Sequential, early-terminating magnitude comparator. Operands are accepted
// through a valid/ready handshake and scanned MSB-first, DIGIT bits per
// cycle; the scan stops at the first unequal digit.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       : operand handshake (accept only in IDLE)
//   a_in, b_in              : WIDTH-bit operands
//   signed_mode             : two's-complement compare (only with CMP_SIGNED_EN)
//   out_valid/out_ready     : result handshake
//   less_than/equal_to/greater_than : one-hot result flags, 0 when !out_valid
//   steps_used              : digits examined for this result (1..STEPS)
// Build option: define CMP_SIGNED_EN to add the signed_mode port.
module seq_digit_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4,
  localparam int unsigned STEPS = WIDTH / DIGIT,
  localparam int unsigned CW = $clog2(STEPS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic [CW-1:0]    steps_used
);

  localparam int unsigned IW = (STEPS > 1) ? $clog2(STEPS) : 1;

  cmp_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_valid, w_valid_nxt;
  logic [2:0]       r_flags, w_flags_nxt;
  logic [CW-1:0]    r_steps, w_steps_nxt;

  logic [DIGIT-1:0] w_dig_a, w_dig_b;
  logic             w_dig_lt, w_dig_eq, w_dig_gt;
  cmp_res_e         w_res;
  logic [WIDTH-1:0] w_cap_a, w_cap_b;

  assign w_dig_a = r_a[32'(r_idx) * DIGIT +: DIGIT];
  assign w_dig_b = r_b[32'(r_idx) * DIGIT +: DIGIT];

  cmp_digit #(
    .DIGIT(DIGIT)
  ) u_cmp_digit (
    .i_a (w_dig_a),
    .i_b (w_dig_b),
    .o_lt(w_dig_lt),
    .o_eq(w_dig_eq),
    .o_gt(w_dig_gt)
  );

  assign w_res = w_dig_lt ? CMP_LT : (w_dig_gt ? CMP_GT : CMP_EQ);

`ifdef CMP_SIGNED_EN
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign w_cap_a = a_in ^ (signed_mode ? MsbMask : '0);
  assign w_cap_b = b_in ^ (signed_mode ? MsbMask : '0);
`else
  assign w_cap_a = a_in;
  assign w_cap_b = b_in;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_flags_nxt = r_flags;
    w_steps_nxt = r_steps;
    unique case (r_state)
      CMP_IDLE: begin
        if (in_valid) begin
          w_a_nxt     = w_cap_a;
          w_b_nxt     = w_cap_b;
          w_idx_nxt   = IW'(STEPS - 1);
          w_cnt_nxt   = '0;
          w_state_nxt = CMP_SCAN;
        end
      end
      CMP_SCAN: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!w_dig_eq || (r_idx == '0)) begin
          w_flags_nxt = cmp_flags(w_res);
          w_steps_nxt = r_cnt + CW'(1);
          w_valid_nxt = 1'b1;
          w_state_nxt = CMP_DONE;
        end else begin
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      CMP_DONE: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_flags_nxt = 3'b000;
          w_state_nxt = CMP_IDLE;
        end
      end
      default: w_state_nxt = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CMP_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_flags <= 3'b000;
      r_steps <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_flags <= w_flags_nxt;
      r_steps <= w_steps_nxt;
    end
  end

  assign in_ready     = (r_state == CMP_IDLE) & ~reset;
  assign out_valid    = r_valid;
  assign less_than    = r_flags[2];
  assign equal_to     = r_flags[1];
  assign greater_than = r_flags[0];
  assign steps_used   = r_steps;

endmodule
